if_id_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage PCPU pipeline.
- Sits directly upstream of the decode Control unit.
- Owns the PC and drives the instruction-memory address; latches fetched instructions.
- Presents decoded fields op/rs/rt/func/rd/shamt/imm to Control and the register file.
- Computes branch/jump/jr redirect targets, applies stall and squash, and keeps fetch/stall/flush counters.

---
 rtl/if_id_stage.sv | 146 ++++++++++++++
 tb/tb_if_id_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// Instruction fetch stage and IF/ID pipeline register for the 5-stage PCPU.
// Owns the PC, resolves branch/jump/jr redirects from ID, and counts fetch/stall/flush events.
module if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        branch,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic [5:0]  op,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  func,
    output logic [15:0] imm,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc4,
    output logic        id_valid,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    localparam int unsigned XLEN    = 32;
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned IMM_W   = 16;
    localparam int unsigned JIDX_W  = 26;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc4;
        logic            valid;
    } ifid_t;

    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  pc_d;
    logic [XLEN-1:0]  pc_plus4;
    ifid_t            ifid_q;
    ifid_t            ifid_d;

    logic [CNT_W-1:0] fetch_cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    logic             redirect;
    logic             fetch_inc;
    logic             flush_inc;
    logic [XLEN-1:0]  br_offset;
    logic [XLEN-1:0]  br_target;
    logic [XLEN-1:0]  j_target;
    logic [IMM_W-1:0] id_imm;
    logic [JIDX_W-1:0] id_jidx;

    // Redirect targets come straight from the instruction held in IF/ID.
    assign id_imm    = ifid_q.inst[IMM_W-1:0];
    assign id_jidx   = ifid_q.inst[JIDX_W-1:0];
    assign br_offset = {{14{id_imm[IMM_W-1]}}, id_imm, 2'b00};
    assign br_target = ifid_q.pc4 + br_offset;
    assign j_target  = {ifid_q.pc4[XLEN-1:XLEN-4], id_jidx, 2'b00};
    assign pc_plus4  = pc_q + XLEN'(4);

    // Control inputs only matter when ID holds a real instruction.
    assign redirect  = ifid_q.valid & (branch | jump | jr);
    assign fetch_inc = ~stall & ~redirect;
    assign flush_inc = ~stall & redirect;

    // Next PC and IF/ID contents; a stall freezes both and defers any redirect.
    always_comb begin
        pc_d   = pc_q;
        ifid_d = ifid_q;
        if (!stall) begin
            ifid_d.pc4 = pc_plus4;
            if (redirect) begin
                ifid_d.inst  = NOP_INST;
                ifid_d.valid = 1'b0;
                if (jr) begin
                    pc_d = jr_target;
                end else if (jump) begin
                    pc_d = j_target;
                end else begin
                    pc_d = br_target;
                end
            end else begin
                ifid_d.inst  = imem_data;
                ifid_d.valid = 1'b1;
                pc_d         = pc_plus4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            ifid_q.inst  <= NOP_INST;
            ifid_q.pc4   <= '0;
            ifid_q.valid <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            ifid_q <= ifid_d;
        end
    end

    // Event counters, free-running and wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (fetch_inc) begin
                fetch_cnt_q <= fetch_cnt_q + CNT_W'(1);
            end
            if (stall) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (flush_inc) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign imem_addr = pc_q;
    assign id_inst   = ifid_q.inst;
    assign id_pc4    = ifid_q.pc4;
    assign id_valid  = ifid_q.valid;
    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    // Decode fields are plain slices, so a bubble reads as all zeros.
    assign op    = ifid_q.inst[31:26];
    assign rs    = ifid_q.inst[25:21];
    assign rt    = ifid_q.inst[20:16];
    assign rd    = ifid_q.inst[15:11];
    assign shamt = ifid_q.inst[10:6];
    assign func  = ifid_q.inst[5:0];
    assign imm   = ifid_q.inst[15:0];

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed scenarios plus randomized control
// traffic compared against a cycle-level behavioural model of the fetch stage.
module tb_if_id_stage;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall;
    logic        branch;
    logic        jump;
    logic        jr;
    logic [31:0] jr_target;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  func;
    logic [15:0] imm;
    logic [31:0] id_inst;
    logic [31:0] id_pc4;
    logic        id_valid;
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    int errors;
    int checks;
    int mem_mode;
    logic [31:0] mem_seed;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic [31:0] m_fetch;
    logic [31:0] m_stall;
    logic [31:0] m_flush;

    if_id_stage dut (
        .clk       (clk),
        .rst       (rst),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .stall     (stall),
        .branch    (branch),
        .jump      (jump),
        .jr        (jr),
        .jr_target (jr_target),
        .op        (op),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .shamt     (shamt),
        .func      (func),
        .imm       (imm),
        .id_inst   (id_inst),
        .id_pc4    (id_pc4),
        .id_valid  (id_valid),
        .fetch_cnt (fetch_cnt),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: mode 0 is the directed table, otherwise a scrambled pattern.
    function automatic logic [31:0] imem_fn(input logic [31:0] a, input int mode, input logic [31:0] seed);
        if (mode == 0) begin
            if (a == 32'h0000_0010) return 32'h1000_FFFC;
            if (a == 32'h4000_000C) return 32'h0800_0100;
            return a | 32'h1000_0000;
        end
        return (a * 32'h9E37_79B1) ^ seed;
    endfunction

    always_comb imem_data = imem_fn(imem_addr, mem_mode, mem_seed);

    // One clock: drive controls, predict the next state from the fetch rules, advance.
    task automatic cycle(input logic r, input logic s, input logic b, input logic jp,
                         input logic jrr, input logic [31:0] jt);
        logic [31:0] n_pc, n_inst, n_pc4, n_fetch, n_stall, n_flush;
        logic        n_valid;
        logic        redir;
        rst = r; stall = s; branch = b; jump = jp; jr = jrr; jr_target = jt;
        n_pc = m_pc; n_inst = m_inst; n_pc4 = m_pc4; n_valid = m_valid;
        n_fetch = m_fetch; n_stall = m_stall; n_flush = m_flush;
        if (r) begin
            n_pc = 32'h0; n_inst = 32'h0; n_pc4 = 32'h0; n_valid = 1'b0;
            n_fetch = 32'h0; n_stall = 32'h0; n_flush = 32'h0;
        end else begin
            redir = m_valid && (b || jp || jrr);
            if (s) begin
                n_stall = m_stall + 1;
            end else if (redir) begin
                n_flush = m_flush + 1;
                n_inst  = 32'h0;
                n_valid = 1'b0;
                n_pc4   = m_pc + 4;
                if (jrr)     n_pc = jt;
                else if (jp) n_pc = {m_pc4[31:28], m_inst[25:0], 2'b00};
                else         n_pc = m_pc4 + 32'(int'($signed(m_inst[15:0])) * 4);
            end else begin
                n_fetch = m_fetch + 1;
                n_inst  = imem_fn(m_pc, mem_mode, mem_seed);
                n_valid = 1'b1;
                n_pc4   = m_pc + 4;
                n_pc    = m_pc + 4;
            end
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_inst = n_inst; m_pc4 = n_pc4; m_valid = n_valid;
        m_fetch = n_fetch; m_stall = n_stall; m_flush = n_flush;
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 1, 1, 1, 1, 32'h1234);
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", imem_addr, 32'h0); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", id_valid); end
        checks++; if ({id_inst, id_pc4} !== 64'h0) begin errors++; $display("FAIL reset_ifid got=%h_%h exp=0", id_inst, id_pc4); end
        checks++; if ({fetch_cnt, stall_cnt, flush_cnt} !== 96'h0) begin errors++; $display("FAIL reset_cnt got=%0d/%0d/%0d exp=0/0/0", fetch_cnt, stall_cnt, flush_cnt); end
    endtask

    task automatic test_free_run();
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            cycle(0, 0, 0, 0, 0, 0);
            checks++; if (imem_addr !== 32'(4 * i)) begin errors++; $display("FAIL run_pc%0d got=%h exp=%h", i, imem_addr, 32'(4 * i)); end
            checks++; if (id_inst !== (32'(4 * (i - 1)) | 32'h1000_0000)) begin errors++; $display("FAIL run_inst%0d got=%h exp=%h", i, id_inst, 32'(4 * (i - 1)) | 32'h1000_0000); end
            checks++; if (id_valid !== 1'b1 || fetch_cnt !== 32'(i)) begin errors++; $display("FAIL run_cnt%0d got=%b/%0d exp=1/%0d", i, id_valid, fetch_cnt, i); end
        end
    endtask

    task automatic test_stall();
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 2; k++) begin
            cycle(0, 1, 0, 0, 0, 0);
            checks++; if (imem_addr !== 32'h8 || id_inst !== 32'h1000_0004) begin errors++; $display("FAIL stall_hold%0d got=%h/%h exp=8/10000004", k, imem_addr, id_inst); end
            checks++; if (stall_cnt !== 32'(k)) begin errors++; $display("FAIL stall_cnt%0d got=%0d exp=%0d", k, stall_cnt, k); end
        end
        cycle(0, 0, 0, 0, 0, 0);
        checks++; if (imem_addr !== 32'hC || id_inst !== 32'h1000_0008 || fetch_cnt !== 32'd3) begin errors++; $display("FAIL stall_resume got=%h/%h/%0d exp=c/10000008/3", imem_addr, id_inst, fetch_cnt); end
    endtask

    task automatic test_branch();
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0, 0);
        checks++; if (id_inst !== 32'h1000_FFFC || id_pc4 !== 32'h14 || imm !== 16'hFFFC) begin errors++; $display("FAIL beq_in_id got=%h/%h exp=1000fffc/14", id_inst, id_pc4); end
        cycle(0, 0, 1, 0, 0, 0);
        checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL beq_target got=%h exp=4", imem_addr); end
        checks++; if (id_valid !== 1'b0 || id_inst !== 32'h0 || op !== 6'h0 || flush_cnt !== 32'd1) begin errors++; $display("FAIL beq_bubble got=%b/%h/%0d exp=0/0/1", id_valid, id_inst, flush_cnt); end
        cycle(0, 0, 1, 1, 1, 32'h55);
        checks++; if (imem_addr !== 32'h8 || id_valid !== 1'b1 || id_inst !== 32'h1000_0004 || flush_cnt !== 32'd1) begin errors++; $display("FAIL bubble_ignore got=%h/%b/%h/%0d exp=8/1/10000004/1", imem_addr, id_valid, id_inst, flush_cnt); end
    endtask

    task automatic test_jump();
        cycle(0, 0, 0, 0, 1, 32'h4000_000C);
        checks++; if (imem_addr !== 32'h4000_000C) begin errors++; $display("FAIL jr_pc got=%h exp=4000000c", imem_addr); end
        cycle(0, 0, 0, 0, 0, 0);
        checks++; if (id_inst !== 32'h0800_0100 || id_pc4 !== 32'h4000_0010) begin errors++; $display("FAIL j_in_id got=%h/%h exp=08000100/40000010", id_inst, id_pc4); end
        cycle(0, 0, 0, 1, 0, 0);
        checks++; if (imem_addr !== 32'h4000_0400 || flush_cnt !== 32'd3) begin errors++; $display("FAIL j_target got=%h/%0d exp=40000400/3", imem_addr, flush_cnt); end
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 1, 32'h80);
        checks++; if (imem_addr !== 32'h80) begin errors++; $display("FAIL jr_priority got=%h exp=80", imem_addr); end
    endtask

    task automatic test_stall_branch();
        logic [31:0] pc_hold, flush_before;
        cycle(0, 0, 0, 0, 0, 0);
        pc_hold = m_pc;
        flush_before = m_flush;
        cycle(0, 1, 1, 0, 0, 0);
        checks++; if (imem_addr !== pc_hold || flush_cnt !== flush_before || id_valid !== 1'b1) begin errors++; $display("FAIL stall_br_hold got=%h/%0d exp=%h/%0d", imem_addr, flush_cnt, pc_hold, flush_before); end
        cycle(0, 0, 1, 0, 0, 0);
        checks++; if (imem_addr !== m_pc || flush_cnt !== flush_before + 1 || id_valid !== 1'b0) begin errors++; $display("FAIL stall_br_redirect got=%h/%0d/%b exp=%h/%0d/0", imem_addr, flush_cnt, id_valid, m_pc, flush_before + 1); end
    endtask

    task automatic test_reset_mid_stall();
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 32'h20);
        cycle(0, 1, 0, 0, 0, 0);
        checks++; if (imem_addr !== 32'h20) begin errors++; $display("FAIL pre_rst_pc got=%h exp=20", imem_addr); end
        cycle(1, 1, 1, 0, 0, 0);
        checks++; if (imem_addr !== 32'h0 || id_valid !== 1'b0 || {fetch_cnt, stall_cnt, flush_cnt} !== 96'h0) begin errors++; $display("FAIL rst_mid_stall got=%h/%b/%0d/%0d/%0d exp=0/0/0/0/0", imem_addr, id_valid, fetch_cnt, stall_cnt, flush_cnt); end
    endtask

    task automatic test_wrap();
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        cycle(0, 0, 0, 0, 0, 0);
        checks++; if (imem_addr !== 32'h0 || id_pc4 !== 32'h0 || id_inst !== 32'hFFFF_FFFC) begin errors++; $display("FAIL pc_wrap got=%h/%h/%h exp=0/0/fffffffc", imem_addr, id_pc4, id_inst); end
        cycle(0, 0, 0, 0, 1, 32'h0000_0123);
        checks++; if (imem_addr !== 32'h0000_0123) begin errors++; $display("FAIL jr_misaligned got=%h exp=123", imem_addr); end
    endtask

    task automatic test_random();
        logic [240:0] obs, expv;
        mem_mode = 1;
        mem_seed = $urandom;
        cycle(1, 0, 0, 0, 0, 0);
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom % 64) == 0, ($urandom % 4) == 0, ($urandom % 4) == 0,
                  ($urandom % 5) == 0, ($urandom % 6) == 0, $urandom);
            obs  = {imem_addr, id_inst, id_pc4, id_valid, fetch_cnt, stall_cnt, flush_cnt,
                    op, rs, rt, rd, shamt, func, imm};
            expv = {m_pc, m_inst, m_pc4, m_valid, m_fetch, m_stall, m_flush,
                    m_inst[31:26], m_inst[25:21], m_inst[20:16], m_inst[15:11],
                    m_inst[10:6], m_inst[5:0], m_inst[15:0]};
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL rand%0d got=%h exp=%h", n, obs, expv);
            end
        end
    endtask

    initial begin
        errors = 0; checks = 0; mem_mode = 0; mem_seed = 32'h0;
        m_pc = 0; m_inst = 0; m_pc4 = 0; m_valid = 0; m_fetch = 0; m_stall = 0; m_flush = 0;
        rst = 1'b1; stall = 1'b0; branch = 1'b0; jump = 1'b0; jr = 1'b0; jr_target = 32'h0;
        test_reset();
        test_free_run();
        test_stall();
        test_branch();
        test_jump();
        test_stall_branch();
        test_reset_mid_stall();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
